// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state, owner and access-type codes shared by the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [2:0] DM_WORD = 3'b000;
endpackage

// File: rtl/mem_port_arbiter_arb_grant_sel.sv
// arb_grant_sel: data-first grant decision with a streak counter that bounds fetch starvation
module arb_grant_sel #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_if_kill,
  input  logic i_state_is_idle,
  output logic o_grant_if,
  output logic o_grant_d
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] r_streak;
  logic w_sat;
  assign w_sat = r_streak == SW'(MAX_STREAK);
  assign o_grant_if = i_state_is_idle & i_if_req & ~i_if_kill & (~i_d_req | w_sat);
  assign o_grant_d = i_state_is_idle & i_d_req & ~o_grant_if;
  always_ff @(posedge clk) begin
    if (reset) r_streak <= '0;
    else if (i_state_is_idle)
      r_streak <= (o_grant_if | ~i_if_req) ? '0 : (o_grant_d & ~w_sat) ? r_streak + 1'b1 : r_streak;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between instruction fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_kill,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ready,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_dmtype,
  output logic [31:0] o_d_rdata,
  output logic        o_d_ready,
  output logic        o_stall_if,
  output logic        o_stall_mem,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_dmtype,
  input  logic [31:0] i_mem_rdata
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  state_t r_state, w_next;
  owner_t r_owner;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [2:0] r_dmtype;
  logic r_we, r_kill, w_grant_if, w_grant_d, w_resp;
  arb_grant_sel #(.MAX_STREAK(MAX_STREAK)) u_sel (
    .clk             (clk),
    .reset           (reset),
    .i_if_req        (i_if_req),
    .i_d_req         (i_d_req),
    .i_if_kill       (i_if_kill),
    .i_state_is_idle (r_state == ST_IDLE),
    .o_grant_if      (w_grant_if),
    .o_grant_d       (w_grant_d)
  );
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE)  ? ((w_grant_if | w_grant_d) ? ST_ISSUE : ST_IDLE) :
             (r_state == ST_ISSUE) ? ST_WAIT :
             (r_state == ST_WAIT)  ? ((r_cnt == '0) ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_IF;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_dmtype <= '0;
      r_we     <= 1'b0;
      r_kill   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == ST_ISSUE) ? CW'(MEM_LAT - 1) : (r_state == ST_WAIT) ? r_cnt - 1'b1 : r_cnt;
      // a flush during a fetch access is remembered until its RESP cycle
      r_kill  <= (r_owner == OWN_IF) && (r_state == ST_ISSUE || r_state == ST_WAIT) && (r_kill | i_if_kill);
      if (w_grant_d) begin
        r_owner  <= OWN_D;
        r_addr   <= i_d_addr;
        r_we     <= i_d_we;
        r_wdata  <= i_d_wdata;
        r_dmtype <= i_d_dmtype;
      end else if (w_grant_if) begin
        r_owner  <= OWN_IF;
        r_addr   <= i_if_addr;
        r_we     <= 1'b0;
        r_wdata  <= '0;
        r_dmtype <= DM_WORD;
      end
    end
  end
  assign w_resp       = r_state == ST_RESP;
  assign o_if_ready   = w_resp & (r_owner == OWN_IF) & ~r_kill & ~i_if_kill;
  assign o_d_ready    = w_resp & (r_owner == OWN_D);
  assign o_if_rdata   = o_if_ready ? i_mem_rdata : '0;
  assign o_d_rdata    = (o_d_ready & ~r_we) ? i_mem_rdata : '0;
  assign o_stall_if   = i_if_req & ~o_if_ready;
  assign o_stall_mem  = i_d_req & ~o_d_ready;
  assign o_mem_en     = r_state == ST_ISSUE;
  assign o_mem_we     = o_mem_en & r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_dmtype = r_dmtype;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: checks two arbiter instances (MEM_LAT 1 and 3) against a timeline model
// of grants, strobes and ready pulses, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] if_req = '0, if_kill = '0, d_req = '0, d_we = '0;
  logic [1:0][31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [1:0][2:0] d_dmtype = '0;
  logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0][2:0] mem_dmtype;
  logic [1:0] if_ready, d_ready, stall_if, stall_mem, mem_en, mem_we;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.MEM_LAT(g == 0 ? 1 : 3), .MAX_STREAK(MAXS)) u_dut (
      .clk          (clk),
      .reset        (rst),
      .i_if_req     (if_req[g]),
      .i_if_addr    (if_addr[g]),
      .i_if_kill    (if_kill[g]),
      .o_if_rdata   (if_rdata[g]),
      .o_if_ready   (if_ready[g]),
      .i_d_req      (d_req[g]),
      .i_d_we       (d_we[g]),
      .i_d_addr     (d_addr[g]),
      .i_d_wdata    (d_wdata[g]),
      .i_d_dmtype   (d_dmtype[g]),
      .o_d_rdata    (d_rdata[g]),
      .o_d_ready    (d_ready[g]),
      .o_stall_if   (stall_if[g]),
      .o_stall_mem  (stall_mem[g]),
      .o_mem_en     (mem_en[g]),
      .o_mem_we     (mem_we[g]),
      .o_mem_addr   (mem_addr[g]),
      .o_mem_wdata  (mem_wdata[g]),
      .o_mem_dmtype (mem_dmtype[g]),
      .i_mem_rdata  (mem_rdata[g])
    );
  end
  int n_cmp = 0, n_bad = 0;
  int k = 0, lat = 1, cyc = 0, g0;
  // model: one outstanding access described by the cycles of its strobe and its ready pulse
  bit busy, own_d, m_we, killed, served_if, served_d;
  int t_en, t_rdy, streak;
  logic [31:0] m_addr, m_wdata;
  logic [2:0] m_dm;
  int obs_en, obs_rdy, n_en, n_rdy;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic obs_we;
  logic [2:0] obs_dm;
  string ord;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (dut %0d cycle %0d)", nm, act, exp, k, cyc);
    end
  endtask
  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask
  task automatic chk_s(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got '%s', want '%s'", nm, act, exp);
    end
  endtask
  task automatic clr_obs();
    obs_en = -1; obs_rdy = -1; n_en = 0; n_rdy = 0; ord = "";
  endtask
  task automatic step();
    bit e_en, rdy, e_ir, e_dr, gi, gd;
    #1;
    e_en = busy && cyc == t_en;
    rdy  = busy && cyc == t_rdy;
    e_ir = rdy && !own_d && !killed && !if_kill[k];
    e_dr = rdy && own_d;
    served_if = e_ir;
    served_d  = e_dr;
    if (!rst) begin
      chkb("mem_en", mem_en[k], e_en);
      chkb("mem_we", mem_we[k], e_en && m_we);
      if (e_en) begin
        chk("mem_addr", mem_addr[k], m_addr);
        chk("mem_dmtype", 32'(mem_dmtype[k]), 32'(m_dm));
        if (m_we) chk("mem_wdata", mem_wdata[k], m_wdata);
      end
      chkb("if_ready", if_ready[k], e_ir);
      chkb("d_ready", d_ready[k], e_dr);
      if (e_ir) chk("if_rdata", if_rdata[k], mem_rdata[k]);
      if (e_dr) chk("d_rdata", d_rdata[k], m_we ? 32'h0 : mem_rdata[k]);
      chkb("stall_if", stall_if[k], if_req[k] && !e_ir);
      chkb("stall_mem", stall_mem[k], d_req[k] && !e_dr);
    end
    if (mem_en[k]) begin
      n_en++;
      if (obs_en < 0) begin
        obs_en = cyc; obs_addr = mem_addr[k]; obs_we = mem_we[k];
        obs_wdata = mem_wdata[k]; obs_dm = mem_dmtype[k];
      end
    end
    if (if_ready[k] || d_ready[k]) begin
      n_rdy++;
      if (d_ready[k]) ord = {ord, "D"};
      else ord = {ord, "I"};
      if (obs_rdy < 0) begin
        obs_rdy = cyc;
        obs_rdata = d_ready[k] ? d_rdata[k] : if_rdata[k];
      end
    end
    @(posedge clk);
    if (rst) begin
      busy = 0; streak = 0; killed = 0;
    end else if (busy) begin
      if (!own_d && if_kill[k]) killed = 1;
      if (cyc == t_rdy) begin busy = 0; killed = 0; end
    end else begin
      gi = if_req[k] && !if_kill[k] && (!d_req[k] || streak == MAXS);
      gd = d_req[k] && !gi;
      if (gi || gd) begin
        busy = 1; own_d = gd; killed = 0;
        t_en = cyc + 1; t_rdy = cyc + 2 + lat;
        m_we = gd && d_we[k];
        m_addr = gd ? d_addr[k] : if_addr[k];
        m_wdata = d_wdata[k];
        m_dm = gd ? d_dmtype[k] : 3'b000;
      end
      streak = (gi || !if_req[k]) ? 0 : (gd && streak < MAXS) ? streak + 1 : streak;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset(input int kk);
    rst = 1; k = kk; lat = (kk == 0) ? 1 : 3;
    if_req = '0; if_kill = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_dmtype = '0; mem_rdata = '0;
    step(); step();
    rst = 0;
  endtask
  task automatic chk_zero();
    #1;
    chkb("rst_mem_en", mem_en[k], 1'b0);
    chkb("rst_mem_we", mem_we[k], 1'b0);
    chkb("rst_if_ready", if_ready[k], 1'b0);
    chkb("rst_d_ready", d_ready[k], 1'b0);
    chk("rst_mem_addr", mem_addr[k], 32'h0);
    chk("rst_mem_wdata", mem_wdata[k], 32'h0);
    chk("rst_mem_dmtype", 32'(mem_dmtype[k]), 32'h0);
    chk("rst_if_rdata", if_rdata[k], 32'h0);
    chk("rst_d_rdata", d_rdata[k], 32'h0);
  endtask
  initial begin
    @(negedge clk);
    clr_obs();
    do_reset(0);
    chk_zero();
    // single load
    clr_obs();
    d_req[0] = 1; d_addr[0] = 32'h40; mem_rdata[0] = 32'hDEADBEEF; g0 = cyc;
    repeat (6) begin step(); if (served_d) d_req[0] = 0; end
    chk("t1_en_cycle", obs_en, g0 + 1);
    chk("t1_addr", obs_addr, 32'h40);
    chkb("t1_we", obs_we, 1'b0);
    chk("t1_ready_cycle", obs_rdy, g0 + 3);
    chk("t1_rdata", obs_rdata, 32'hDEADBEEF);
    // both requesters held: bounded data streak
    do_reset(0); clr_obs();
    if_req[0] = 1; d_req[0] = 1;
    repeat (45) step();
    chk_s("t2_order", ord.substr(0, 9), "DDDDIDDDDI");
    // store
    do_reset(0); clr_obs();
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h80; d_wdata[0] = 32'h12345678; d_dmtype[0] = 3'b000;
    mem_rdata[0] = 32'h55AA55AA; g0 = cyc;
    repeat (6) begin step(); if (served_d) d_req[0] = 0; end
    chkb("t3_we", obs_we, 1'b1);
    chk("t3_addr", obs_addr, 32'h80);
    chk("t3_wdata", obs_wdata, 32'h12345678);
    chk("t3_dmtype", 32'(obs_dm), 32'h0);
    chk("t3_en_count", n_en, 1);
    chk("t3_ready_cycle", obs_rdy, g0 + 3);
    chk("t3_rdata", obs_rdata, 32'h0);
    // fetch flushed during WAIT, then a fresh fetch
    do_reset(0); clr_obs();
    if_req[0] = 1; if_addr[0] = 32'h100; mem_rdata[0] = 32'h00000013;
    step(); step();
    if_kill[0] = 1; step();
    if_kill[0] = 0; if_addr[0] = 32'h200; step();
    chk("t4_killed_en", n_en, 1);
    chk("t4_killed_addr", obs_addr, 32'h100);
    chk("t4_killed_ready", n_rdy, 0);
    clr_obs();
    repeat (6) begin step(); if (served_if) if_req[0] = 0; end
    chk("t4_next_addr", obs_addr, 32'h200);
    chk("t4_next_ready", n_rdy, 1);
    chk("t4_next_rdata", obs_rdata, 32'h00000013);
    // reset in the middle of a load
    do_reset(0); clr_obs();
    d_req[0] = 1; d_addr[0] = 32'h44; mem_rdata[0] = 32'hCAFEF00D;
    step(); step();
    rst = 1; step(); rst = 0;
    chk_zero();
    chk("t5_no_ready", n_rdy, 0);
    g0 = cyc;
    repeat (6) begin step(); if (served_d) d_req[0] = 0; end
    chk("t5_regrant_ready", obs_rdy, g0 + 3);
    chk("t5_ready_count", n_rdy, 1);
    // longer memory latency
    do_reset(1); clr_obs();
    if_req[1] = 1; if_addr[1] = 32'h300; mem_rdata[1] = 32'h01234567; g0 = cyc;
    repeat (10) begin step(); if (served_if) if_req[1] = 0; end
    chk("t6_en_cycle", obs_en, g0 + 1);
    chk("t6_en_count", n_en, 1);
    chk("t6_latency", obs_rdy - obs_en, 4);
    chk("t6_rdata", obs_rdata, 32'h01234567);
    // random traffic on both instances
    for (int kk = 0; kk < 2; kk++) begin
      do_reset(kk);
      repeat (1500) begin
        if (!if_req[k] || served_if) if_req[k] = $urandom_range(0, 2) != 0;
        if (!d_req[k] || served_d) d_req[k] = $urandom_range(0, 2) != 0;
        if_kill[k] = $urandom_range(0, 15) == 0;
        d_we[k] = 1'($urandom);
        if_addr[k] = $urandom; d_addr[k] = $urandom; d_wdata[k] = $urandom;
        d_dmtype[k] = 3'($urandom); mem_rdata[k] = $urandom;
        step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
